// File: rtl/result_reader_if.sv
// Command and beat-stream handshake bundle for result_reader.
// slave is the reader side; master is the side that issues commands and consumes beats.
interface result_reader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int BEAT_WIDTH = 64
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_base;
    logic [ADDR_WIDTH:0]   cmd_len;
    logic                  m_valid;
    logic                  m_ready;
    logic [BEAT_WIDTH-1:0] m_data;
    logic                  m_last;

    modport slave (
        input  cmd_valid, cmd_base, cmd_len, m_ready,
        output cmd_ready, m_valid, m_data, m_last
    );

    modport master (
        output cmd_valid, cmd_base, cmd_len, m_ready,
        input  cmd_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/result_reader.sv
// Drains a run of output-BRAM lines and streams each line out as BPL beats, LSB beat first.
// One line is in flight at a time: FETCH issues the read, LOAD captures it, SEND emits the beats.
module result_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    result_reader_if.slave        io,
    output logic [ADDR_WIDTH-1:0] bram_c_addr,
    output logic                  bram_c_en,
    input  logic [LINE_WIDTH-1:0] bram_c_dout,
    output logic                  done
);
    localparam int BPL   = LINE_WIDTH / BEAT_WIDTH;
    localparam int IDX_W = (BPL > 1) ? $clog2(BPL) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(BPL - 1);
    localparam logic [ADDR_WIDTH:0] ONE_LINE = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

    state_t                           state_q, state_d;
    logic [ADDR_WIDTH-1:0]            line_addr_q, line_addr_d;
    logic [ADDR_WIDTH-1:0]            bram_addr_q, bram_addr_d;
    logic [ADDR_WIDTH:0]              remain_q, remain_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [BPL-1:0][BEAT_WIDTH-1:0]   line_q, line_d;
    logic                             en_q, en_d;
    logic                             valid_q, valid_d;
    logic                             last_q, last_d;
    logic                             done_q, done_d;

    assign io.cmd_ready = (state_q == IDLE) && !rst;
    assign io.m_valid   = valid_q;
    assign io.m_last    = last_q;
    assign io.m_data    = line_q[idx_q];
    assign bram_c_addr  = bram_addr_q;
    assign bram_c_en    = en_q;
    assign done         = done_q;

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        bram_addr_d = bram_addr_q;
        remain_d    = remain_q;
        idx_d       = idx_q;
        line_d      = line_q;
        valid_d     = valid_q;
        last_d      = last_q;
        en_d        = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (io.cmd_valid) begin
                    line_addr_d = io.cmd_base;
                    remain_d    = io.cmd_len;
                    if (io.cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        bram_addr_d = io.cmd_base;
                        en_d        = 1'b1;
                        state_d     = FETCH;
                    end
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                line_d  = bram_c_dout;
                idx_d   = '0;
                valid_d = 1'b1;
                last_d  = (BPL == 1) && (remain_q == ONE_LINE);
                state_d = SEND;
            end
            SEND: begin
                if (io.m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        // Address wraps naturally at the top of the BRAM.
                        if (remain_q > ONE_LINE) begin
                            remain_d    = remain_q - ONE_LINE;
                            line_addr_d = line_addr_q + ADDR_WIDTH'(1);
                            bram_addr_d = line_addr_q + ADDR_WIDTH'(1);
                            en_d        = 1'b1;
                            state_d     = FETCH;
                        end else begin
                            remain_d = '0;
                            done_d   = 1'b1;
                            state_d  = IDLE;
                        end
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        last_d = ((idx_q + IDX_W'(1)) == LAST_IDX) && (remain_q == ONE_LINE);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            line_addr_q <= '0;
            bram_addr_q <= '0;
            remain_q    <= '0;
            idx_q       <= '0;
            line_q      <= '0;
            en_q        <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            bram_addr_q <= bram_addr_d;
            remain_q    <= remain_d;
            idx_q       <= idx_d;
            line_q      <= line_d;
            en_q        <= en_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: expected beats are queued when a command is issued
// and popped as the reader presents accepted beats.
module tb_result_reader;
    logic         clk = 1'b0;
    logic         rst;
    logic [9:0]   bram_c_addr;
    logic         bram_c_en;
    logic [255:0] bram_c_dout;
    logic         done;

    logic [255:0] mem [1024];
    logic [9:0]   rd_log [$];

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } beat_t;
    beat_t sbq [$];

    int vectors = 0;
    int errors  = 0;

    result_reader_if #(.ADDR_WIDTH(10), .BEAT_WIDTH(64)) bus ();

    result_reader #(.ADDR_WIDTH(10), .LINE_WIDTH(256), .BEAT_WIDTH(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .io          (bus.slave),
        .bram_c_addr (bram_c_addr),
        .bram_c_en   (bram_c_en),
        .bram_c_dout (bram_c_dout),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_c_en) begin
            bram_c_dout <= mem[bram_c_addr];
            rd_log.push_back(bram_c_addr);
        end
    end

    task automatic push_line(input int a, input bit fin);
        beat_t e;
        logic [255:0] ln;
        ln = mem[a];
        for (int k = 0; k < 4; k++) begin
            e.d = ln[k*64 +: 64];
            e.l = fin && (k == 3);
            sbq.push_back(e);
        end
    endtask

    task automatic issue(input logic [9:0] b, input logic [10:0] l);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = b;
        bus.cmd_len   = l;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.m_valid, bus.m_last, done, bram_c_en, bus.cmd_ready} !== 5'b0 ||
            bram_c_addr !== 10'd0 || bus.m_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v%b l%b d%b en%b rdy%b addr%h data%h required all zero",
                     bus.m_valid, bus.m_last, done, bram_c_en, bus.cmd_ready, bram_c_addr, bus.m_data);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_single_line();
        beat_t e;
        int dn_c = 0;
        int idx;
        bus.m_ready = 1'b1;
        e.l = 1'b0; e.d = 64'h1111111111111111; sbq.push_back(e);
        e.d = 64'h2222222222222222; sbq.push_back(e);
        e.d = 64'h3333333333333333; sbq.push_back(e);
        e.l = 1'b1; e.d = 64'h4444444444444444; sbq.push_back(e);
        issue(10'd5, 11'd1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            vectors++;
            if (bram_c_en !== (c == 1) || (c == 1 && bram_c_addr !== 10'd5)) begin
                errors++;
                $display("FAIL single_fetch c=%0d: got en%b addr%0d required en%b addr5", c, bram_c_en, bram_c_addr, c == 1);
            end
            if (bus.m_valid) begin
                idx = 4 - sbq.size();
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL single_extra_beat c=%0d: got %h required none", c, bus.m_data);
                end else begin
                    e = sbq.pop_front();
                    vectors++;
                    if ({bus.m_data, bus.m_last} !== {e.d, e.l} || c != 3 + idx) begin
                        errors++;
                        $display("FAIL single_beat c=%0d: got %h/%b required %h/%b at c=%0d", c, bus.m_data, bus.m_last, e.d, e.l, 3 + idx);
                    end
                end
            end
            if (done) dn_c = (dn_c == 0) ? c : -1;
        end
        vectors++;
        if (dn_c != 7 || sbq.size() != 0) begin
            errors++;
            $display("FAIL single_done: got done cycle %0d left %0d required 7 and 0", dn_c, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_wrap();
        beat_t e;
        int dn_c = 0;
        rd_log.delete();
        bus.m_ready = 1'b1;
        push_line(1022, 1'b0);
        push_line(1023, 1'b0);
        push_line(0, 1'b1);
        issue(10'd1022, 11'd3);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.m_valid) begin
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_extra_beat c=%0d: got %h required none", c, bus.m_data);
                end else begin
                    e = sbq.pop_front();
                    vectors++;
                    if ({bus.m_data, bus.m_last} !== {e.d, e.l}) begin
                        errors++;
                        $display("FAIL wrap_beat c=%0d: got %h/%b required %h/%b", c, bus.m_data, bus.m_last, e.d, e.l);
                    end
                end
            end
            if (done) dn_c = (dn_c == 0) ? c : -1;
        end
        vectors++;
        if (dn_c != 19 || sbq.size() != 0) begin
            errors++;
            $display("FAIL wrap_done: got done cycle %0d left %0d required 19 and 0", dn_c, sbq.size());
            sbq.delete();
        end
        vectors++;
        if (rd_log.size() != 3 || rd_log[0] != 10'd1022 || rd_log[1] != 10'd1023 || rd_log[2] != 10'd0) begin
            errors++;
            $display("FAIL wrap_reads: got %0d reads required 1022,1023,0", rd_log.size());
        end
    endtask

    task automatic test_backpressure();
        beat_t e;
        logic [3:0]  pat = 4'b1001;
        logic        stalled = 1'b0;
        logic        pl = 1'b0;
        logic [63:0] pd = '0;
        int dn = 0;
        push_line(7, 1'b1);
        issue(10'd7, 11'd1);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (stalled) begin
                vectors++;
                if ({bus.m_valid, bus.m_last, bus.m_data} !== {1'b1, pl, pd}) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d: got v%b l%b %h required v1 l%b %h", c, bus.m_valid, bus.m_last, bus.m_data, pl, pd);
                end
            end
            bus.m_ready = pat[c % 4];
            if (bus.m_valid && bus.m_ready) begin
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL stall_extra_beat c=%0d: got %h required none", c, bus.m_data);
                end else begin
                    e = sbq.pop_front();
                    vectors++;
                    if ({bus.m_data, bus.m_last} !== {e.d, e.l}) begin
                        errors++;
                        $display("FAIL stall_beat c=%0d: got %h/%b required %h/%b", c, bus.m_data, bus.m_last, e.d, e.l);
                    end
                end
            end
            stalled = bus.m_valid && !bus.m_ready;
            pd = bus.m_data;
            pl = bus.m_last;
            if (done) dn++;
        end
        bus.m_ready = 1'b1;
        vectors++;
        if (dn != 1 || sbq.size() != 0) begin
            errors++;
            $display("FAIL stall_done: got %0d dones left %0d required 1 and 0", dn, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_len0();
        int dn_c = 0;
        rd_log.delete();
        issue(10'd3, 11'd0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            vectors++;
            if (bram_c_en !== 1'b0 || bus.m_valid !== 1'b0) begin
                errors++;
                $display("FAIL len0_quiet c=%0d: got en%b v%b required 0 0", c, bram_c_en, bus.m_valid);
            end
            if (done) dn_c = (dn_c == 0) ? c : -1;
        end
        vectors++;
        if (dn_c != 1 || rd_log.size() != 0) begin
            errors++;
            $display("FAIL len0_done: got done cycle %0d reads %0d required 1 and 0", dn_c, rd_log.size());
        end
    endtask

    task automatic test_abort();
        beat_t e;
        int dn = 0;
        bus.m_ready = 1'b1;
        push_line(20, 1'b0);
        void'(sbq.pop_back());
        void'(sbq.pop_back());
        issue(10'd20, 11'd2);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 5) begin
                bus.m_ready = 1'b0;
                rst = 1'b1;
            end
            if (c == 6) begin
                vectors++;
                if ({bus.m_valid, bus.m_last, done, bram_c_en, bus.cmd_ready} !== 5'b0 ||
                    bram_c_addr !== 10'd0 || bus.m_data !== 64'd0) begin
                    errors++;
                    $display("FAIL abort_reset_out: got v%b l%b d%b en%b rdy%b addr%h data%h required all zero",
                             bus.m_valid, bus.m_last, done, bram_c_en, bus.cmd_ready, bram_c_addr, bus.m_data);
                end
            end
            if (c == 7) begin
                vectors++;
                if (bus.cmd_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_ready: got %b required 1", bus.cmd_ready);
                end
            end
            if (bus.m_valid && bus.m_ready) begin
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL abort_extra_beat c=%0d: got %h required none", c, bus.m_data);
                end else begin
                    e = sbq.pop_front();
                    vectors++;
                    if ({bus.m_data, bus.m_last} !== {e.d, e.l}) begin
                        errors++;
                        $display("FAIL abort_beat c=%0d: got %h/%b required %h/%b", c, bus.m_data, bus.m_last, e.d, e.l);
                    end
                end
            end
            if (done) dn++;
            if (c == 6) begin
                rst = 1'b0;
                bus.m_ready = 1'b1;
            end
        end
        vectors++;
        if (dn != 0 || sbq.size() != 0) begin
            errors++;
            $display("FAIL abort_done: got %0d dones left %0d required 0 and 0", dn, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_back_to_back();
        beat_t e;
        int hs_c = 0;
        int extra = 0;
        int d1 = 0;
        int d2 = 0;
        bus.m_ready = 1'b1;
        push_line(30, 1'b1);
        push_line(40, 1'b1);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = 10'd30;
        bus.cmd_len   = 11'd1;
        @(posedge clk);
        #1 bus.cmd_base = 10'd40;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (hs_c != 0 && c == hs_c + 1) bus.cmd_valid = 1'b0;
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (hs_c == 0) hs_c = c;
                else extra++;
            end
            if (bus.m_valid) begin
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_beat c=%0d: got %h required none", c, bus.m_data);
                end else begin
                    e = sbq.pop_front();
                    vectors++;
                    if ({bus.m_data, bus.m_last} !== {e.d, e.l}) begin
                        errors++;
                        $display("FAIL b2b_beat c=%0d: got %h/%b required %h/%b", c, bus.m_data, bus.m_last, e.d, e.l);
                    end
                end
            end
            if (done) begin
                if (d1 == 0) d1 = c;
                else if (d2 == 0) d2 = c;
                else extra++;
            end
        end
        bus.cmd_valid = 1'b0;
        vectors++;
        if (hs_c != 7 || extra != 0) begin
            errors++;
            $display("FAIL b2b_handshake: got second at %0d extra %0d required 7 and 0", hs_c, extra);
        end
        vectors++;
        if (d1 != 7 || d2 != 14 || sbq.size() != 0) begin
            errors++;
            $display("FAIL b2b_done: got %0d,%0d left %0d required 7,14 and 0", d1, d2, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.m_ready   = 1'b1;
        for (int a = 0; a < 1024; a++) begin
            for (int k = 0; k < 4; k++) begin
                mem[a][k*64 +: 64] = {16'(a), 16'(k), 32'h9E3779B9 ^ 32'(a * 4 + k)};
            end
        end
        mem[5] = {64'h4444444444444444, 64'h3333333333333333,
                  64'h2222222222222222, 64'h1111111111111111};

        test_reset();
        test_single_line();
        repeat (3) @(negedge clk);
        test_wrap();
        repeat (3) @(negedge clk);
        test_backpressure();
        repeat (3) @(negedge clk);
        test_len0();
        repeat (3) @(negedge clk);
        test_abort();
        repeat (3) @(negedge clk);
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, which sets the output BRAM word-address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 256, which sets the output BRAM word width in bits.
REQ-003 SHALL have parameter BEAT_WIDTH, default 64, which sets the stream beat width; LINE_WIDTH/BEAT_WIDTH (BPL, default 4) is an integer.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 cmd_valid  in  1  drain command present.
REQ-007 cmd_ready  out  1  block accepts a command.
REQ-008 cmd_base  in  ADDR_WIDTH  first output-BRAM line to read.
REQ-009 cmd_len  in  ADDR_WIDTH+1  number of lines to read (0..2^ADDR_WIDTH).
REQ-010 bram_c_addr  out  ADDR_WIDTH  read address to output BRAM (1-cycle read latency).
REQ-011 bram_c_en  out  1  read enable.
REQ-012 bram_c_dout  in  LINE_WIDTH  read data, valid the cycle after the enabled address.
REQ-013 m_valid  out  1  beat valid.
REQ-014 m_ready  in  1  downstream accepts beat.
REQ-015 m_data  out  BEAT_WIDTH  beat payload.
REQ-016 m_last  out  1  final beat of command.
REQ-017 done  out  1  one-cycle pulse, command complete.

Function
REQ-018 SHALL implement states IDLE, FETCH, LOAD, SEND.
REQ-019 cmd_ready SHALL be 1 exactly when the state is IDLE and rst is 0.
REQ-020 A handshake SHALL occur when cmd_valid&cmd_ready; at that edge, cmd_base and cmd_len SHALL be latched.
REQ-021 A handshake with cmd_len=0 SHALL stay in IDLE, pulse done the next cycle, and produce no BRAM read and no beat.
REQ-022 A handshake with cmd_len>0 SHALL go to FETCH.
REQ-023 FETCH: bram_c_en=1 and bram_c_addr=current line address for one cycle, then go to LOAD.
REQ-024 LOAD: bram_c_dout SHALL be captured into a line register at the end of the cycle, beat index cleared, then go to SEND.
REQ-025 SEND: m_valid=1, and m_data=line[(idx+1)*BEAT_WIDTH-1 : idx*BEAT_WIDTH] (beat 0 = LSBs).
REQ-026 idx SHALL advance only on m_valid&m_ready.
REQ-027 While m_valid&!m_ready, m_data, m_last and m_valid SHALL hold stable.
REQ-028 On acceptance of beat BPL-1: if lines remain, the line address SHALL increment and the state go to FETCH; otherwise the state SHALL go to IDLE and done SHALL pulse the next cycle.
REQ-029 Line address SHALL wrap modulo 2^ADDR_WIDTH (base 1023, len 2 reads 1023 then 0).
REQ-030 m_last SHALL be 1 only on beat BPL-1 of the final line.
REQ-031 bram_c_en SHALL be 0 outside FETCH; bram_c_addr SHALL hold its last value outside FETCH.
REQ-032 Latency: a command accepted at edge T SHALL give FETCH in T+1, LOAD in T+2, and beat 0 valid in T+3; with m_ready held 1, each line SHALL take 6 cycles.
REQ-033 cmd_valid while busy SHALL be ignored (not latched) until IDLE.
REQ-034 The block SHALL never write the BRAM.

Reset
REQ-035 rst=1 at any edge, including mid-command, SHALL force IDLE and clear line count, idx and line register.
REQ-036 During and after reset: m_valid=0, m_last=0, done=0, bram_c_en=0, bram_c_addr=0, m_data=0.
REQ-037 An aborted command SHALL produce no done and no further beats.

Verification
REQ-038 base=5, len=1, line5=0x4444..._3333..._2222..._1111..., m_ready=1 -> beats 0x1111.., 0x2222.., 0x3333.., 0x4444.. in cycles T+3..T+6, m_last on 4th, done at T+7.
REQ-039 base=1022, len=3 -> reads at addresses 1022, 1023, 0 in order, 12 beats, m_last only on beat 12.
REQ-040 m_ready toggling 1,0,0,1 during SEND -> m_data stable through stalls, no beat dropped or duplicated, idx advances only on handshakes.
REQ-041 len=0 -> done one cycle after handshake, m_valid and bram_c_en never 1.
REQ-042 rst asserted after beat 2 of a len=2 command -> next cycle m_valid=0, IDLE, cmd_ready=1 after rst falls, no done.
REQ-043 cmd_valid held high during an active command -> only one handshake; second command accepted only after done.
